// File: rtl/prod_bcd_conv.sv
// rtl/prod_bcd_conv.sv - sequential shift-add-3 binary-to-BCD converter for the mymul product
//
// Ports:
//   clk    - single clock, all state changes on the rising edge
//   rst    - synchronous active-high reset, aborts any conversion in flight
//   start  - conversion request, sampled only while idle
//   p      - N-bit binary value, captured on the edge that accepts start
//   busy   - high while a conversion is running
//   done   - one-cycle pulse when bcd has just been updated
//   bcd    - DIGITS packed BCD digits, units in [3:0]; holds the last completed result

module prod_bcd_conv #(
  parameter int N      = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N-1:0]          p,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [N-1:0]    bin_q;
  logic [BW-1:0]   scratch_q;
  logic [BW-1:0]   scratch_adj;
  logic [BW-1:0]   scratch_shifted;
  logic [CW-1:0]   cnt_q;
  logic            last_iter;

  // Add-3 correction on each digit independently; a digit >= 5 would
  // overflow past 9 when doubled, so it is pre-biased before the shift.
  always_comb begin
    scratch_adj = scratch_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5) begin
        scratch_adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
      end
    end
  end

  // Upper half of the {scratch, binary} left shift: the binary MSB enters
  // the units digit.
  assign scratch_shifted = {scratch_adj[BW-2:0], bin_q[N-1]};
  assign last_iter       = (cnt_q == CW'(N - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = SHIFT;
      SHIFT:   if (last_iter) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_q     <= p;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_shifted;
          bin_q     <= {bin_q[N-2:0], 1'b0};
          cnt_q     <= cnt_q + 1'b1;
          if (last_iter) begin
            // Only the final post-shift scratch value is ever published.
            bcd  <= scratch_shifted;
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prod_bcd_conv.sv
// tb/tb_prod_bcd_conv.sv - directed self-checking bench for prod_bcd_conv

module tb_prod_bcd_conv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] p;
  logic        busy;
  logic        done;
  logic [19:0] bcd;

  int errors;
  int checks;

  prod_bcd_conv #(.N(16), .DIGITS(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .p     (p),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle (or showing done). Drives start,
  // optionally pulses a second start at edge count inj_at, and returns at
  // the negedge where done is visible.
  task automatic do_conv(input string tag, input logic [15:0] pv, input logic [19:0] exp_bcd,
                         input logic [19:0] hold_bcd, input int inj_at, input logic [15:0] inj_p);
    int  edges;
    bit  hold_bad;
    bit  overlap;
    bit  busy_bad;
    start = 1'b1;
    p     = pv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    p     = 16'($urandom);
    edges = 0;
    hold_bad = 0;
    overlap  = 0;
    busy_bad = 0;
    while (!done && edges < 40) begin
      if (bcd !== hold_bcd) hold_bad = 1;
      if (busy !== 1'b1) busy_bad = 1;
      if (edges == inj_at) begin
        start = 1'b1;
        p     = inj_p;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      edges++;
      if (busy && done) overlap = 1;
    end
    start = 1'b0;
    check({tag, "_latency"}, edges, 16);
    check({tag, "_bcd"}, bcd, exp_bcd);
    check({tag, "_busy_low"}, busy, 1'b0);
    check({tag, "_hold_and_busy"}, {hold_bad, busy_bad, overlap}, 3'b000);
  endtask

  task automatic idle_watch(input string tag, input int cycles);
    bit seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check(tag, seen, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    start  = 1'b0;
    p      = 16'd0;

    repeat (3) @(negedge clk);
    start = 1'b1;
    p     = 16'd77;
    @(negedge clk);
    start = 1'b0;
    check("rst_bcd", bcd, 20'h00000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    idle_watch("idle_no_done", 20);
    check("idle_bcd", bcd, 20'h00000);

    do_conv("mul_255x255", 16'd65025, 20'h65025, 20'h00000, -1, 16'd0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    do_conv("mul_7x11",    16'd77,    20'h00077, 20'h65025, -1, 16'd0);
    do_conv("mul_123x246", 16'd30258, 20'h30258, 20'h00077, -1, 16'd0);
    do_conv("mul_168x195", 16'd32760, 20'h32760, 20'h30258, -1, 16'd0);
    do_conv("zero",        16'd0,     20'h00000, 20'h32760, -1, 16'd0);
    do_conv("max",         16'd65535, 20'h65535, 20'h00000, -1, 16'd0);
    do_conv("d9999",       16'd9999,  20'h09999, 20'h65535, -1, 16'd0);

    do_conv("b2b_first",   16'd4840,  20'h04840, 20'h09999, -1, 16'd0);
    do_conv("b2b_second",  16'd6534,  20'h06534, 20'h04840, -1, 16'd0);

    @(negedge clk);
    do_conv("start_busy",  16'd1694,  20'h01694, 20'h06534, 4, 16'd1234);
    idle_watch("start_busy_no_second", 24);
    check("start_busy_bcd_kept", bcd, 20'h01694);

    start = 1'b1;
    p     = 16'd65025;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_bcd", bcd, 20'h00000);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    idle_watch("abort_no_done", 24);
    do_conv("after_abort", 16'd77, 20'h00077, 20'h00000, -1, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
